// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM with byte strobes, programmable wait states,
// request/ready acceptance and a one-cycle response pulse.
//
// state  | meaning
// S_IDLE | ready, no request in flight
// S_WAIT | request latched, counting down wait states
// S_RESP | rvalid pulse; may accept the next request back-to-back
module data_mem_responder #(
  parameter int    ADDR_WIDTH = 12,
  parameter int    LATENCY    = 1,
  parameter string INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        err
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              q_we;
  logic [31:0]       q_addr;
  logic [31:0]       q_wdata;
  logic [3:0]        q_wstrb;
  logic [31:0]       mem [DEPTH];

  logic              take;
  logic              go_resp;
  logic              c_we;
  logic              c_err;
  logic [31:0]       c_addr;
  logic [31:0]       c_wdata;
  logic [3:0]        c_wstrb;
  logic [ADDR_WIDTH-1:0] c_idx;

  assign ready = !reset && (state != S_WAIT);
  assign take  = req && ready;

  // With zero wait states the access commits on the acceptance edge, so the
  // committed request comes straight from the ports rather than the latch.
  always_comb begin
    if (state == S_WAIT) begin
      c_we    = q_we;
      c_addr  = q_addr;
      c_wdata = q_wdata;
      c_wstrb = q_wstrb;
    end else begin
      c_we    = we;
      c_addr  = addr;
      c_wdata = wdata;
      c_wstrb = wstrb;
    end
    c_idx   = c_addr[ADDR_WIDTH+1:2];
    c_err   = (c_addr[1:0] != 2'b00) || (c_addr[31:ADDR_WIDTH+2] != '0);
    go_resp = !reset && (((state == S_WAIT) && (cnt == 4'd1)) ||
                         (take && (LATENCY == 0)));
  end

  always_ff @(posedge clk) begin
    if (go_resp && c_we && !c_err) begin
      for (int i = 0; i < 4; i++) begin
        if (c_wstrb[i]) mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      rvalid  <= 1'b0;
      rdata   <= 32'h0;
      err     <= 1'b0;
      q_we    <= 1'b0;
      q_addr  <= 32'h0;
      q_wdata <= 32'h0;
      q_wstrb <= 4'h0;
    end else begin
      rvalid <= go_resp;
      err    <= go_resp && c_err;
      rdata  <= (go_resp && !c_we && !c_err) ? mem[c_idx] : 32'h0;
      case (state)
        S_IDLE, S_RESP: begin
          if (take) begin
            q_we    <= we;
            q_addr  <= addr;
            q_wdata <= wdata;
            q_wstrb <= wstrb;
            cnt     <= 4'(LATENCY);
            state   <= (LATENCY == 0) ? S_RESP : S_WAIT;
          end else begin
            state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd1) state <= S_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
